// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg
// Shared definitions for the UART TX scheduler slice:
//   - FSM state encodings (IDLE/SEND/WAIT_ACK/WAIT_DONE)
//   - requester IDs used by the round-robin arbiter (CPU/DBG)
//   - default FIFO depth and sender acknowledge timeout
package uart_tx_scheduler_pkg;

  localparam int DATA_W              = 8;
  localparam int TMO_W               = 8;
  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_ACK_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
// Bundles the producer request/grant pairs, the sender handshake and the
// status outputs of the UART TX scheduler.
//   master : byte producers + UART sender side (drives reqs, data, TX_STATUS)
//   slave  : the scheduler (drives grants, TX_EN/TX_DATA, fifo_count, tx_busy)
interface uart_tx_scheduler_if #(
  parameter int DEPTH = uart_tx_scheduler_pkg::DEFAULT_DEPTH
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                                    cpu_req;
  logic [uart_tx_scheduler_pkg::DATA_W-1:0] cpu_data;
  logic                                    cpu_gnt;
  logic                                    dbg_req;
  logic [uart_tx_scheduler_pkg::DATA_W-1:0] dbg_data;
  logic                                    dbg_gnt;
  logic                                    TX_EN;
  logic [uart_tx_scheduler_pkg::DATA_W-1:0] TX_DATA;
  logic                                    TX_STATUS;
  logic [CNT_W-1:0]                        fifo_count;
  logic                                    tx_busy;

  modport master (
    output cpu_req, cpu_data, dbg_req, dbg_data, TX_STATUS,
    input  cpu_gnt, dbg_gnt, TX_EN, TX_DATA, fifo_count, tx_busy
  );

  modport slave (
    input  cpu_req, cpu_data, dbg_req, dbg_data, TX_STATUS,
    output cpu_gnt, dbg_gnt, TX_EN, TX_DATA, fifo_count, tx_busy
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous byte FIFO between the arbiter and the TX sequencer.
// Ports:
//   clk, reset      : system clock, synchronous active-low reset
//   push, push_data : enqueue one byte (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   head_data       : oldest entry, valid when !empty
//   count           : occupancy, one bit wider than the pointers
//   full, empty     : occupancy flags
// Storage is not reset; reset only clears pointers and count, which
// discards every queued byte.
module uart_tx_fifo
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Arbitrates the UART transmitter between the CPU MEM-stage store and the
// hardware debug/trace port, queues accepted bytes in uart_tx_fifo and walks
// the serial sender through its TX_EN / TX_STATUS handshake.
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : uart_tx_scheduler_if.slave
//           cpu_req/cpu_data/cpu_gnt, dbg_req/dbg_data/dbg_gnt : producers
//           TX_EN/TX_DATA/TX_STATUS                          : sender
//           fifo_count/tx_busy                               : status
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ACK_TIMEOUT);

  function automatic logic [TMO_W-1:0] tmo_inc(input logic [TMO_W-1:0] v);
    return (v >= TMO_MAX) ? TMO_MAX : v + TMO_W'(1);
  endfunction

  logic              can_push;
  logic              cpu_wins_tie;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              load_data;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  req_id_e           last_gnt;

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TMO_W-1:0]  tmo_nxt;
  logic              tx_en_q;
  logic [DATA_W-1:0] tx_data_q;

  // Arbiter: space is judged on the registered count, so a pop in this
  // cycle never opens a slot for a same-cycle grant.
  assign can_push     = reset && !fifo_full;
  assign cpu_wins_tie = (last_gnt == REQ_DBG);
  assign cpu_gnt      = can_push && bus.cpu_req && (!bus.dbg_req || cpu_wins_tie);
  assign dbg_gnt      = can_push && bus.dbg_req && (!bus.cpu_req || !cpu_wins_tie);
  assign push         = cpu_gnt || dbg_gnt;
  assign push_data    = cpu_gnt ? bus.cpu_data : bus.dbg_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_gnt <= REQ_DBG;
    end else if (cpu_gnt) begin
      last_gnt <= REQ_CPU;
    end else if (dbg_gnt) begin
      last_gnt <= REQ_DBG;
    end
  end

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sender sequencer: state register, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      tx_en_q <= (state_nxt == SEND);
      if (load_data) begin
        tx_data_q <= head_data;
      end
    end
  end

  // The head is only popped once the sender has visibly taken the byte
  // (TX_STATUS low); a re-pulse after timeout resends the unchanged head.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    pop       = 1'b0;
    load_data = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && bus.TX_STATUS) begin
          state_nxt = SEND;
          load_data = 1'b1;
        end
      end
      SEND: begin
        tmo_nxt   = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!bus.TX_STATUS) begin
          pop       = 1'b1;
          state_nxt = WAIT_DONE;
        end else begin
          tmo_nxt = tmo_inc(tmo_cnt);
          if (tmo_inc(tmo_cnt) == TMO_MAX) begin
            state_nxt = SEND;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.TX_STATUS) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.TX_EN      = tx_en_q;
  assign bus.TX_DATA    = tx_data_q;
  assign bus.fifo_count = fifo_count;
  assign bus.tx_busy    = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler (DEPTH=4, ACK_TIMEOUT=8). A sender
// model either answers TX_EN automatically (TX_STATUS low 3 cycles after
// TX_EN, high again 10 cycles later) or TX_STATUS is driven by hand.
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_scheduler_if #(.DEPTH(4)) bus ();

  uart_tx_scheduler #(
    .DEPTH       (4),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic       sender_auto;
  logic       man_st;
  logic       model_st = 1'b1;
  int         drop_at  = -1;
  int         rise_at  = -1;
  logic [7:0] tx_log[$];

  assign bus.TX_STATUS = sender_auto ? model_st : man_st;

  always @(negedge clk) begin
    if (sender_auto) begin
      if (cyc == drop_at) model_st <= 1'b0;
      if (cyc == rise_at) model_st <= 1'b1;
    end
    if (bus.TX_EN) begin
      tx_log.push_back(bus.TX_DATA);
      if (sender_auto) begin
        drop_at <= cyc + 3;
        rise_at <= cyc + 13;
      end
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    sender_auto  = 1'b1;
    man_st       = 1'b1;
    reset        = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_data = 8'h00;
    bus.dbg_req  = 1'b0;
    bus.dbg_data = 8'h00;
    step();
    step();

    // Reset state
    chk("rst_tx_en",   32'(bus.TX_EN), 32'h0);
    chk("rst_tx_data", 32'(bus.TX_DATA), 32'h0);
    chk("rst_busy",    32'(bus.tx_busy), 32'h0);
    chk("rst_count",   32'(bus.fifo_count), 32'h0);
    bus.cpu_req = 1'b1;
    bus.dbg_req = 1'b1;
    #1;
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'h0);
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    reset = 1'b1;
    step();

    // Single CPU byte, latency and handshake
    tx_log.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 8'hA5;
    #1;
    chk("t1_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    chk("t1_dbg_gnt", 32'(bus.dbg_gnt), 32'h0);
    step();
    bus.cpu_req = 1'b0;
    chk("t1_c1_count", 32'(bus.fifo_count), 32'h1);
    chk("t1_c1_tx_en", 32'(bus.TX_EN), 32'h0);
    chk("t1_c1_busy",  32'(bus.tx_busy), 32'h1);
    step();
    chk("t1_c2_tx_en",   32'(bus.TX_EN), 32'h1);
    chk("t1_c2_tx_data", 32'(bus.TX_DATA), 32'hA5);
    step();
    chk("t1_c3_tx_en", 32'(bus.TX_EN), 32'h0);
    chk("t1_c3_count", 32'(bus.fifo_count), 32'h1);
    step();
    step();
    chk("t1_c5_count", 32'(bus.fifo_count), 32'h1);
    step();
    chk("t1_c6_count", 32'(bus.fifo_count), 32'h0);
    chk("t1_c6_busy",  32'(bus.tx_busy), 32'h1);
    repeat (9) step();
    chk("t1_c15_busy", 32'(bus.tx_busy), 32'h1);
    step();
    chk("t1_c16_busy", 32'(bus.tx_busy), 32'h0);

    // Round-robin with both requesters held
    reset = 1'b0;
    step();
    reset = 1'b1;
    tx_log.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 8'h11;
    bus.dbg_req  = 1'b1;
    bus.dbg_data = 8'h22;
    #1;
    chk("rr0_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    chk("rr0_dbg_gnt", 32'(bus.dbg_gnt), 32'h0);
    step();
    bus.cpu_data = 8'h33;
    #1;
    chk("rr1_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    chk("rr1_dbg_gnt", 32'(bus.dbg_gnt), 32'h1);
    step();
    bus.dbg_data = 8'h44;
    #1;
    chk("rr2_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    chk("rr2_dbg_gnt", 32'(bus.dbg_gnt), 32'h0);
    step();
    #1;
    chk("rr3_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    chk("rr3_dbg_gnt", 32'(bus.dbg_gnt), 32'h1);
    step();
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    for (int k = 0; k < 300 && tx_log.size() < 4; k++) step();
    chk("rr_log_size", 32'(tx_log.size()), 32'h4);
    chk("rr_order0", 32'(tx_log[0]), 32'h11);
    chk("rr_order1", 32'(tx_log[1]), 32'h22);
    chk("rr_order2", 32'(tx_log[2]), 32'h33);
    chk("rr_order3", 32'(tx_log[3]), 32'h44);
    for (int k = 0; k < 100 && bus.tx_busy; k++) step();
    chk("rr_idle", 32'(bus.tx_busy), 32'h0);

    // Fill to DEPTH with the sender held busy, then drain 10 bytes
    sender_auto = 1'b0;
    man_st      = 1'b0;
    tx_log.delete();
    for (int i = 0; i < 4; i++) begin
      bus.cpu_req  = 1'b1;
      bus.cpu_data = 8'(8'h30 + i);
      #1;
      chk("fill_gnt", 32'(bus.cpu_gnt), 32'h1);
      step();
    end
    bus.cpu_data = 8'h34;
    #1;
    chk("full_gnt",   32'(bus.cpu_gnt), 32'h0);
    chk("full_count", 32'(bus.fifo_count), 32'h4);
    chk("full_tx_en", 32'(bus.TX_EN), 32'h0);
    step();
    chk("full_gnt_hold", 32'(bus.cpu_gnt), 32'h0);
    man_st = 1'b1;
    #1;
    chk("full_gnt_start", 32'(bus.cpu_gnt), 32'h0);
    step();
    chk("full_tx_en_send", 32'(bus.TX_EN), 32'h1);
    chk("full_tx_data",    32'(bus.TX_DATA), 32'h30);
    man_st = 1'b0;
    #1;
    chk("full_gnt_send", 32'(bus.cpu_gnt), 32'h0);
    step();
    chk("full_gnt_popcyc",   32'(bus.cpu_gnt), 32'h0);
    chk("full_count_popcyc", 32'(bus.fifo_count), 32'h4);
    step();
    chk("full_count_after", 32'(bus.fifo_count), 32'h3);
    chk("full_gnt_after",   32'(bus.cpu_gnt), 32'h1);
    step();
    sender_auto = 1'b1;
    idx = 5;
    for (int k = 0; k < 600 && (idx < 10 || tx_log.size() < 10); k++) begin
      if (idx < 10) begin
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 8'(8'h30 + idx);
      end else begin
        bus.cpu_req = 1'b0;
      end
      #1;
      if (bus.cpu_gnt) idx++;
      step();
    end
    bus.cpu_req = 1'b0;
    chk("wrap_log_size", 32'(tx_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_order", 32'(tx_log[i]), 32'(8'h30 + i));
    end
    for (int k = 0; k < 100 && bus.tx_busy; k++) step();
    chk("wrap_idle", 32'(bus.tx_busy), 32'h0);

    // Sender never acknowledges: TX_EN re-pulses every ACK_TIMEOUT+1 cycles
    sender_auto  = 1'b0;
    man_st       = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 8'hC3;
    #1;
    chk("tmo_gnt", 32'(bus.cpu_gnt), 32'h1);
    step();
    bus.cpu_req = 1'b0;
    step();
    chk("tmo_c2_tx_en",   32'(bus.TX_EN), 32'h1);
    chk("tmo_c2_tx_data", 32'(bus.TX_DATA), 32'hC3);
    repeat (8) step();
    chk("tmo_c10_tx_en", 32'(bus.TX_EN), 32'h0);
    step();
    chk("tmo_c11_tx_en",   32'(bus.TX_EN), 32'h1);
    chk("tmo_c11_tx_data", 32'(bus.TX_DATA), 32'hC3);
    chk("tmo_c11_count",   32'(bus.fifo_count), 32'h1);
    repeat (9) step();
    chk("tmo_c20_tx_en", 32'(bus.TX_EN), 32'h1);
    chk("tmo_c20_count", 32'(bus.fifo_count), 32'h1);

    // Reset while in WAIT_ACK with 3 bytes queued
    step();
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 8'hD1;
    #1;
    chk("rstq_gnt1", 32'(bus.cpu_gnt), 32'h1);
    step();
    bus.cpu_data = 8'hD2;
    #1;
    chk("rstq_gnt2", 32'(bus.cpu_gnt), 32'h1);
    step();
    bus.cpu_req = 1'b0;
    chk("rstq_count3", 32'(bus.fifo_count), 32'h3);
    reset        = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 8'hD3;
    bus.dbg_req  = 1'b1;
    #1;
    chk("rstq_cpu_gnt_forced", 32'(bus.cpu_gnt), 32'h0);
    chk("rstq_dbg_gnt_forced", 32'(bus.dbg_gnt), 32'h0);
    step();
    chk("rstq_tx_en",   32'(bus.TX_EN), 32'h0);
    chk("rstq_tx_data", 32'(bus.TX_DATA), 32'h0);
    chk("rstq_busy",    32'(bus.tx_busy), 32'h0);
    chk("rstq_count",   32'(bus.fifo_count), 32'h0);
    reset       = 1'b1;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    n = tx_log.size();
    repeat (20) step();
    chk("rstq_no_tx", 32'(tx_log.size()), 32'(n));
    chk("rstq_busy_after", 32'(bus.tx_busy), 32'h0);

    // Push and pop in the same cycle at count=2
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 8'h7E;
    #1;
    chk("pp_gnt0", 32'(bus.cpu_gnt), 32'h1);
    step();
    bus.cpu_req = 1'b0;
    step();
    chk("pp_tx_en",   32'(bus.TX_EN), 32'h1);
    chk("pp_tx_data", 32'(bus.TX_DATA), 32'h7E);
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 8'h81;
    #1;
    chk("pp_gnt1", 32'(bus.cpu_gnt), 32'h1);
    step();
    chk("pp_count_before", 32'(bus.fifo_count), 32'h2);
    bus.cpu_data = 8'h82;
    man_st       = 1'b0;
    #1;
    chk("pp_gnt2", 32'(bus.cpu_gnt), 32'h1);
    step();
    chk("pp_count_after", 32'(bus.fifo_count), 32'h2);
    bus.cpu_req = 1'b0;
    man_st      = 1'b1;
    step();
    step();
    chk("pp_next_tx_en",   32'(bus.TX_EN), 32'h1);
    chk("pp_next_tx_data", 32'(bus.TX_DATA), 32'h81);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
